// File: rtl/barrier_scheduler.sv
// barrier_scheduler: frame-paced lane scheduler for the barrier generator,
// with a shrinking gap between barriers and a dodged-barrier counter.
module barrier_scheduler #(
    parameter int unsigned GAP_FRAMES    = 60,
    parameter int unsigned MIN_GAP       = 20,
    parameter int unsigned GAP_STEP      = 4,
    parameter int unsigned SPEEDUP_EVERY = 8,
    parameter int unsigned SHOW_FRAMES   = 150,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_v_sync,
    input  logic        i_enable,
    input  logic        i_penguin_hit,
    output logic [1:0]  o_active,
    output logic        o_spawn_pulse,
    output logic [15:0] o_dodged_count,
    output logic [7:0]  o_cur_gap
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;

    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] MASK      = 16'hB400;
    localparam logic [7:0]  GAP_INIT  = 8'(GAP_FRAMES);
    localparam logic [7:0]  GAP_MIN   = 8'(MIN_GAP);
    localparam logic [8:0]  STEP9     = 9'(GAP_STEP);
    localparam logic [7:0]  SHOW_LAST = 8'(SHOW_FRAMES - 1);
    localparam logic [7:0]  SPD_LAST  = 8'(SPEEDUP_EVERY - 1);

    logic [2:0]  vs_q;
    logic        frame_tick;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  lane;
    logic [1:0]  state_q, state_d;
    logic [7:0]  frame_q, frame_d;
    logic [7:0]  bar_q, bar_d;
    logic        hit_q, hit_d;
    logic        hit_now;
    logic [1:0]  active_q, active_d;
    logic        spawn_q, spawn_d;
    logic [15:0] dodged_q, dodged_d;
    logic [7:0]  gap_q, gap_d;
    logic [8:0]  gap_diff;
    logic [7:0]  gap_next;

    // vs_q[1:0] synchronize v_sync, vs_q[2] holds the previous synced level
    assign frame_tick = vs_q[1] & ~vs_q[2];

    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? MASK : 16'h0000);
    assign lane   = (lfsr_q[1:0] == 2'b00) ? 2'b10 : lfsr_q[1:0];

    // Borrow out of the 9-bit difference means the step overshot zero
    assign gap_diff = {1'b0, gap_q} - STEP9;
    assign gap_next = (gap_diff[8] || (gap_diff[7:0] < GAP_MIN)) ? GAP_MIN
                                                                 : gap_diff[7:0];

    assign hit_now = hit_q | i_penguin_hit;

    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        bar_d    = bar_q;
        hit_d    = hit_q;
        active_d = active_q;
        spawn_d  = 1'b0;
        dodged_d = dodged_q;
        gap_d    = gap_q;
        if (!i_enable) begin
            state_d  = S_IDLE;
            frame_d  = 8'd0;
            active_d = 2'b00;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d  = S_GAP;
                    frame_d  = 8'd0;
                    active_d = 2'b00;
                end
                S_GAP: begin
                    active_d = 2'b00;
                    if (frame_tick) begin
                        if (frame_q == gap_q - 8'd1) begin
                            state_d  = S_SHOW;
                            active_d = lane;
                            spawn_d  = 1'b1;
                            hit_d    = 1'b0;
                            frame_d  = 8'd0;
                        end else begin
                            frame_d = frame_q + 8'd1;
                        end
                    end
                end
                S_SHOW: begin
                    hit_d = hit_now;
                    if (frame_tick) begin
                        if (frame_q == SHOW_LAST) begin
                            state_d  = S_GAP;
                            frame_d  = 8'd0;
                            active_d = 2'b00;
                            if (!hit_now && dodged_q != 16'hFFFF) begin
                                dodged_d = dodged_q + 16'd1;
                            end
                            if (bar_q == SPD_LAST) begin
                                bar_d = 8'd0;
                                gap_d = gap_next;
                            end else begin
                                bar_d = bar_q + 8'd1;
                            end
                        end else begin
                            frame_d = frame_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    frame_d  = 8'd0;
                    active_d = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vs_q     <= 3'b000;
            lfsr_q   <= SEED;
            state_q  <= S_IDLE;
            frame_q  <= 8'd0;
            bar_q    <= 8'd0;
            hit_q    <= 1'b0;
            active_q <= 2'b00;
            spawn_q  <= 1'b0;
            dodged_q <= 16'd0;
            gap_q    <= GAP_INIT;
        end else begin
            vs_q     <= {vs_q[1:0], i_v_sync};
            lfsr_q   <= lfsr_d;
            state_q  <= state_d;
            frame_q  <= frame_d;
            bar_q    <= bar_d;
            hit_q    <= hit_d;
            active_q <= active_d;
            spawn_q  <= spawn_d;
            dodged_q <= dodged_d;
            gap_q    <= gap_d;
        end
    end

    assign o_active       = active_q;
    assign o_spawn_pulse  = spawn_q;
    assign o_dodged_count = dodged_q;
    assign o_cur_gap      = gap_q;

endmodule

// File: tb/tb_barrier_scheduler.sv
// tb_barrier_scheduler: table-driven barrier sequences plus a frame-level
// reference model checked every cycle under randomized hits/enable/reset.
module tb_barrier_scheduler;

    localparam int GAP0  = 10;
    localparam int MING  = 3;
    localparam int STEP  = 4;
    localparam int SPD   = 2;
    localparam int SHOW  = 2;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        rst_n;
    logic        v_sync;
    logic        en;
    logic        pen;
    logic [1:0]  o_active;
    logic        o_spawn;
    logic [15:0] o_dodged;
    logic [7:0]  o_gap;

    int n_chk;
    int n_fail;
    bit chk_on;
    bit vs_restart;
    int ph;
    int vs_rises;

    barrier_scheduler #(
        .GAP_FRAMES(GAP0),
        .MIN_GAP(MING),
        .GAP_STEP(STEP),
        .SPEEDUP_EVERY(SPD),
        .SHOW_FRAMES(SHOW),
        .LFSR_SEED(SEED)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_v_sync(v_sync),
        .i_enable(en),
        .i_penguin_hit(pen),
        .o_active(o_active),
        .o_spawn_pulse(o_spawn),
        .o_dodged_count(o_dodged),
        .o_cur_gap(o_gap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame source: 10-clock period, high for 5 clocks, restartable
    initial begin
        ph = 9;
        v_sync = 1'b0;
        vs_rises = 0;
        forever begin
            @(negedge clk);
            #1;
            if (vs_restart) begin
                ph = 0;
                vs_restart = 1'b0;
            end else begin
                ph = (ph + 1) % 10;
            end
            if (ph == 0 && !v_sync) vs_rises++;
            v_sync = (ph < 5);
        end
    end

    // Reference model: phase + countdown of frames left in the phase
    int         m_phase;
    int         m_left;
    int         m_gap;
    int         m_dodged;
    int         m_bars;
    bit         m_hit;
    bit [1:0]   m_active;
    bit         m_spawn;
    bit [15:0]  m_lfsr;
    bit         vh [3];

    always @(posedge clk) begin : model
        bit       tick;
        bit [1:0] ln;
        bit       h;
        int       ng;
        tick = vh[1] & ~vh[2];
        ln = (m_lfsr[1:0] == 2'b00) ? 2'b10 : m_lfsr[1:0];
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_gap = GAP0; m_dodged = 0;
            m_bars = 0; m_hit = 0; m_active = 0; m_spawn = 0;
            m_lfsr = SEED;
            vh[0] = 0; vh[1] = 0; vh[2] = 0;
        end else begin
            vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = v_sync;
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            m_spawn = 0;
            if (!en) begin
                m_phase = 0;
                m_active = 0;
            end else if (m_phase == 0) begin
                m_phase = 1;
                m_left = m_gap;
            end else if (m_phase == 1) begin
                if (tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = 2; m_active = ln; m_spawn = 1;
                        m_hit = 0; m_left = SHOW;
                    end
                end
            end else begin
                h = m_hit | pen;
                m_hit = h;
                if (tick) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (!h && m_dodged < 65535) m_dodged++;
                        m_bars++;
                        if (m_bars == SPD) begin
                            m_bars = 0;
                            ng = m_gap - STEP;
                            m_gap = (ng < MING) ? MING : ng;
                        end
                        m_phase = 1; m_left = m_gap; m_active = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_chk++;
            if ({o_active, o_spawn, o_dodged, o_gap} !==
                {m_active, m_spawn, 16'(m_dodged), 8'(m_gap)}) begin
                n_fail++;
                $display("FAIL model t=%0t act=%0h/%0h spawn=%0b/%0b dodged=%0d/%0d gap=%0d/%0d (got/exp)",
                         $time, o_active, m_active, o_spawn, m_spawn,
                         o_dodged, m_dodged, o_gap, m_gap);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0; pen = 1'b0; vs_restart = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Enable just before v_sync falls so no frame tick is in flight
    task automatic start_enable();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ph != 4 && n < 20);
        en = 1'b1;
    endtask

    // mode 0: plain, 1: one-cycle hit in SHOW, 2: return right after spawn
    task automatic run_barrier(input int mode, output int gapf,
                               output int showf, output logic [1:0] ln);
        int r0;
        int n;
        gapf = 0; showf = 0; ln = 2'b00;
        r0 = vs_rises;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_spawn && n < 1000);
        if (!o_spawn) begin
            chk("spawn_timeout", 0, 1);
            return;
        end
        gapf = vs_rises - r0;
        ln = o_active;
        if (mode == 2) return;
        if (mode == 1) begin
            @(negedge clk); pen = 1'b1;
            @(negedge clk); pen = 1'b0;
        end
        r0 = vs_rises;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_active != 2'b00 && n < 1000);
        if (o_active != 2'b00) begin
            chk("show_timeout", 0, 1);
            return;
        end
        showf = vs_rises - r0;
    endtask

    typedef struct {
        int mode;
        int exp_gapf;
        int exp_showf;
        int exp_dodged;
        int exp_gap;
    } vec_t;

    vec_t       tbl [8];
    logic [1:0] la [64];
    bit         seen [4];

    initial begin
        int gf;
        int sf;
        logic [1:0] ln;
        tbl[0] = '{0, 10, 2, 1, 10};
        tbl[1] = '{0, 10, 2, 2, 6};
        tbl[2] = '{0, 6, 2, 3, 6};
        tbl[3] = '{0, 6, 2, 4, 3};
        tbl[4] = '{0, 3, 2, 5, 3};
        tbl[5] = '{1, 3, 2, 5, 3};
        tbl[6] = '{0, 3, 2, 6, 3};
        tbl[7] = '{0, 3, 2, 7, 3};
        n_chk = 0; n_fail = 0; chk_on = 1'b0; vs_restart = 1'b0;
        rst_n = 1'b0; en = 1'b0; pen = 1'b0;
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;

        do_reset();
        chk_on = 1'b1;

        // Lane sweep with random hits
        start_enable();
        for (int i = 0; i < 64; i++) begin
            run_barrier(($urandom_range(0, 3) == 0) ? 1 : 0, gf, sf, ln);
            la[i] = ln;
            chk("lane_nonzero", int'(ln != 2'b00), 1);
            seen[ln] = 1'b1;
        end
        chk("all_lanes_seen", int'(seen[1] & seen[2] & seen[3]), 1);

        // Reset values, then the barrier table
        do_reset();
        chk("rst_active", o_active, 0);
        chk("rst_spawn", o_spawn, 0);
        chk("rst_dodged", o_dodged, 0);
        chk("rst_gap", o_gap, GAP0);
        start_enable();
        for (int i = 0; i < 8; i++) begin
            run_barrier(tbl[i].mode, gf, sf, ln);
            chk($sformatf("gap_frames[%0d]", i), gf, tbl[i].exp_gapf);
            chk($sformatf("show_frames[%0d]", i), sf, tbl[i].exp_showf);
            chk($sformatf("dodged[%0d]", i), o_dodged, tbl[i].exp_dodged);
            chk($sformatf("cur_gap[%0d]", i), o_gap, tbl[i].exp_gap);
            chk($sformatf("lane_repeat[%0d]", i), ln, la[i]);
        end

        // Drop enable mid-SHOW, then re-enable
        run_barrier(2, gf, sf, ln);
        chk("drop_gap_frames", gf, 3);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("drop_active", o_active, 0);
        chk("drop_dodged", o_dodged, 7);
        repeat (30) @(negedge clk);
        chk("idle_active", o_active, 0);
        chk("idle_dodged", o_dodged, 7);
        start_enable();
        run_barrier(2, gf, sf, ln);
        chk("reenable_gap_frames", gf, 3);
        chk("reenable_dodged", o_dodged, 7);

        // One-cycle reset mid-SHOW
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_active", o_active, 0);
        chk("midrst_spawn", o_spawn, 0);
        chk("midrst_dodged", o_dodged, 0);
        chk("midrst_gap", o_gap, GAP0);

        // Random hits, enable toggles and rare resets against the model
        start_enable();
        repeat (4000) begin
            @(negedge clk);
            pen = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) en = ~en;
            rst_n = ($urandom_range(0, 799) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
